// File: rtl/sevenseg_reader.sv
// Seven-segment receiver: synchronizes the segment lines, debounces them and
// decodes the shown hex digit, flagging steps, jumps and illegal patterns.
module sevenseg_reader #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned ACTIVE_LOW    = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_seg,
    output logic [3:0] o_digit,
    output logic       o_valid,
    output logic       o_blank,
    output logic       o_new,
    output logic       o_up,
    output logic       o_down,
    output logic       o_err,
    output logic       o_err_sticky
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [6:0] DARK = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    typedef enum logic {
        ST_WAIT,
        ST_LOCKED
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  sync1_q, sync1_d;
    logic [6:0]  sync2_q, sync2_d;
    logic [6:0]  held_q, held_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]  digit_q, digit_d;
    logic        valid_q, valid_d;
    logic        blank_q, blank_d;
    logic        new_q, new_d;
    logic        up_q, up_d;
    logic        down_q, down_d;
    logic        err_q, err_d;
    logic        sticky_q, sticky_d;

    logic [6:0]  seg;
    logic        accept;
    logic [3:0]  dec_digit;
    logic        dec_legal;
    logic        dec_blank;

    assign sync1_d = i_seg;
    assign sync2_d = sync1_q;
    assign seg     = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

    always_comb begin
        dec_digit = 4'h0;
        dec_legal = 1'b1;
        dec_blank = 1'b0;
        case (held_q)
            7'h3F: dec_digit = 4'h0;
            7'h06: dec_digit = 4'h1;
            7'h5B: dec_digit = 4'h2;
            7'h4F: dec_digit = 4'h3;
            7'h66: dec_digit = 4'h4;
            7'h6D: dec_digit = 4'h5;
            7'h7D: dec_digit = 4'h6;
            7'h47: dec_digit = 4'h7;
            7'h7F: dec_digit = 4'h8;
            7'h67: dec_digit = 4'h9;
            7'h77: dec_digit = 4'hA;
            7'h7C: dec_digit = 4'hB;
            7'h58: dec_digit = 4'hC;
            7'h5E: dec_digit = 4'hD;
            7'h7B: dec_digit = 4'hE;
            7'h71: dec_digit = 4'hF;
            7'h00: begin
                dec_legal = 1'b0;
                dec_blank = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        held_d   = held_q;
        count_d  = count_q;
        digit_d  = digit_q;
        valid_d  = valid_q;
        blank_d  = blank_q;
        sticky_d = sticky_q;
        new_d    = 1'b0;
        up_d     = 1'b0;
        down_d   = 1'b0;
        err_d    = 1'b0;
        accept   = 1'b0;

        if (seg != held_q) begin
            held_d  = seg;
            count_d = CW'(1);
            state_d = ST_WAIT;
        end else if (state_q == ST_WAIT) begin
            // One more matching sample after the window fills triggers accept
            if (count_q == CNT_MAX) begin
                accept  = 1'b1;
                state_d = ST_LOCKED;
            end else begin
                count_d = count_q + CW'(1);
            end
        end

        if (accept) begin
            if (dec_blank) begin
                blank_d = 1'b1;
            end else if (dec_legal) begin
                blank_d = 1'b0;
                if (!valid_q || dec_digit != digit_q) begin
                    digit_d = dec_digit;
                    valid_d = 1'b1;
                    new_d   = 1'b1;
                    up_d    = valid_q && (dec_digit == digit_q + 4'd1);
                    down_d  = valid_q && (dec_digit == digit_q - 4'd1);
                end
            end else begin
                err_d    = 1'b1;
                sticky_d = 1'b1;
                blank_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_WAIT;
            sync1_q  <= DARK;
            sync2_q  <= DARK;
            held_q   <= 7'h00;
            count_q  <= '0;
            digit_q  <= 4'h0;
            valid_q  <= 1'b0;
            blank_q  <= 1'b0;
            new_q    <= 1'b0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            held_q   <= held_d;
            count_q  <= count_d;
            digit_q  <= digit_d;
            valid_q  <= valid_d;
            blank_q  <= blank_d;
            new_q    <= new_d;
            up_q     <= up_d;
            down_q   <= down_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
        end
    end

    assign o_digit      = digit_q;
    assign o_valid      = valid_q;
    assign o_blank      = blank_q;
    assign o_new        = new_q;
    assign o_up         = up_q;
    assign o_down       = down_q;
    assign o_err        = err_q;
    assign o_err_sticky = sticky_q;

endmodule

// File: tb/tb_sevenseg_reader.sv
// Bench for sevenseg_reader: run-length reference model checked every cycle,
// plus directed sequences with hand-computed expectations.
module tb_sevenseg_reader;

    localparam int S = 4;

    logic       clk;
    logic       rst;
    logic [6:0] i_seg;
    logic [3:0] o_digit;
    logic       o_valid, o_blank, o_new, o_up, o_down, o_err, o_err_sticky;

    int checks = 0;
    int errors = 0;
    int n_new = 0, n_up = 0, n_down = 0, n_err = 0;

    sevenseg_reader #(.STABLE_CYCLES(S), .ACTIVE_LOW(1)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_seg(i_seg),
        .o_digit(o_digit),
        .o_valid(o_valid),
        .o_blank(o_blank),
        .o_new(o_new),
        .o_up(o_up),
        .o_down(o_down),
        .o_err(o_err),
        .o_err_sticky(o_err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Active-high segment patterns of digits 0..F
    logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h47,
                             7'h7F, 7'h67, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h7B, 7'h71};

    // Model: raw samples reach the decision point two edges late; a pattern is
    // accepted when its run of observed samples reaches S+1.
    logic [6:0] m_d1, m_seg;
    logic [7:0] m_last;
    int         m_run;
    logic [3:0] m_digit;
    logic       m_valid, m_blank, m_new, m_up, m_down, m_err, m_sticky;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_d1 <= 7'h7F; m_seg <= 7'h7F; m_last <= 8'hFF; m_run <= 0;
            m_digit <= 0; m_valid <= 0; m_blank <= 0; m_new <= 0;
            m_up <= 0; m_down <= 0; m_err <= 0; m_sticky <= 0;
        end else begin
            int run;
            int dg;
            logic [6:0] hs;
            logic [3:0] d4;
            run = ({1'b0, m_seg} == m_last) ? ((m_run < S + 2) ? m_run + 1 : m_run) : 1;
            m_run  <= run;
            m_last <= {1'b0, m_seg};
            m_seg  <= m_d1;
            m_d1   <= i_seg;
            m_new <= 0; m_up <= 0; m_down <= 0; m_err <= 0;
            if (run == S + 1) begin
                hs = ~m_seg;
                dg = -1;
                for (int k = 0; k < 16; k++) if (pat[k] == hs) dg = k;
                d4 = 4'(dg);
                if (hs == 7'h00) begin
                    m_blank <= 1;
                end else if (dg >= 0) begin
                    m_blank <= 0;
                    if (!m_valid || d4 != m_digit) begin
                        m_digit <= d4;
                        m_valid <= 1;
                        m_new   <= 1;
                        m_up    <= m_valid && (dg == (int'(m_digit) + 1) % 16);
                        m_down  <= m_valid && (dg == (int'(m_digit) + 15) % 16);
                    end
                end else begin
                    m_err <= 1; m_sticky <= 1; m_blank <= 0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        check("digit", o_digit, m_digit);
        check("valid", o_valid, m_valid);
        check("blank", o_blank, m_blank);
        check("new", o_new, m_new);
        check("up", o_up, m_up);
        check("down", o_down, m_down);
        check("err", o_err, m_err);
        check("sticky", o_err_sticky, m_sticky);
        n_new  += int'(o_new);
        n_up   += int'(o_up);
        n_down += int'(o_down);
        n_err  += int'(o_err);
    end

    task automatic hold(input logic [6:0] v, input int n);
        i_seg = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        n_new = 0; n_up = 0; n_down = 0; n_err = 0;
    endtask

    task automatic expect_counts(input string t, input int nw, input int u, input int d, input int e);
        check({t, "_n_new"}, n_new, nw);
        check({t, "_n_up"}, n_up, u);
        check({t, "_n_down"}, n_down, d);
        check({t, "_n_err"}, n_err, e);
    endtask

    initial begin
        rst = 1'b1;
        i_seg = 7'h7F;
        repeat (2) @(negedge clk);
        check("rst_digit", o_digit, 0);
        check("rst_valid", o_valid, 0);
        check("rst_blank", o_blank, 0);

        // Digit 0 appears at release: accepted exactly after edge 6
        rst = 1'b0;
        i_seg = 7'h40;
        repeat (6) begin
            @(posedge clk); #3;
            check("t1_quiet", o_new, 0);
        end
        @(posedge clk); #3;
        check("t1_new", o_new, 1);
        check("t1_up", o_up, 0);
        check("t1_down", o_down, 0);
        check("t1_digit", o_digit, 0);
        check("t1_valid", o_valid, 1);
        @(posedge clk); #3;
        check("t1_single", o_new, 0);
        @(negedge clk);

        clr(); hold(7'h79, 10);
        expect_counts("t2_up", 1, 1, 0, 0);
        check("t2_d1", o_digit, 1);
        clr(); hold(7'h40, 10);
        expect_counts("t2_down", 1, 0, 1, 0);
        check("t2_d0", o_digit, 0);
        clr(); hold(7'h30, 10);
        expect_counts("t2_jump", 1, 0, 0, 0);
        check("t2_d3", o_digit, 3);

        clr(); hold(7'h0E, 10);
        expect_counts("t3_toF", 1, 0, 0, 0);
        check("t3_dF", o_digit, 15);
        clr(); hold(7'h40, 10);
        expect_counts("t3_wrapup", 1, 1, 0, 0);
        clr(); hold(7'h0E, 10);
        expect_counts("t3_wrapdn", 1, 0, 1, 0);
        hold(7'h40, 10);

        clr(); hold(7'h79, 3); hold(7'h40, 10);
        expect_counts("t4_glitch", 0, 0, 0, 0);
        check("t4_d0", o_digit, 0);

        clr(); hold(7'h7E, 8);
        expect_counts("t5_err", 0, 0, 0, 1);
        check("t5_sticky", o_err_sticky, 1);
        check("t5_d0", o_digit, 0);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("t5_rst_sticky", o_err_sticky, 0);
        check("t5_rst_valid", o_valid, 0);
        check("t5_rst_digit", o_digit, 0);
        check("t5_rst_blank", o_blank, 0);
        @(negedge clk);
        rst = 1'b0;
        clr(); hold(7'h7F, 8);
        expect_counts("t5_dark", 0, 0, 0, 0);
        check("t5_dark_blank", o_blank, 1);

        hold(7'h12, 10);
        check("t6_d5", o_digit, 5);
        clr(); hold(7'h7F, 8);
        expect_counts("t6_blank", 0, 0, 0, 0);
        check("t6_blank_on", o_blank, 1);
        clr(); hold(7'h12, 10);
        expect_counts("t6_back", 0, 0, 0, 0);
        check("t6_blank_off", o_blank, 0);
        check("t6_d5b", o_digit, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
